inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 8, program-ROM address width.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rom_addr  output  ADDRWIDTH  byte address to program ROM (equals PC).
REQ-005 SHALL have port rom_cs  output  1  ROM chip select, active low.
REQ-006 SHALL have port rom_data  input  8  ROM read data; ROM registers address on falling clk edge.
REQ-007 SHALL have port ins_valid  output  1  assembled instruction available.
REQ-008 SHALL have port ins_ready  input  1  consumer accepts instruction.
REQ-009 SHALL have port ins_opcode, ins_op1, ins_op2  output  8 each  opcode and operand bytes; unused operands 0x00.
REQ-010 SHALL have port ins_len  output  2  instruction length in bytes (1..3).
REQ-011 SHALL have port ins_pc  output  ADDRWIDTH  address of the opcode byte.
REQ-012 SHALL have port ins_illegal  output  1  opcode outside supported set.
REQ-013 SHALL have port jmp_en  input  1  redirect request; jmp_addr  input  ADDRWIDTH  target.

Function
REQ-014 SHALL use FSM states FETCH_OP, FETCH_B1, FETCH_B2, HOLD.
REQ-015 SHALL drive rom_cs=0 in FETCH_* states and rom_cs=1 in HOLD; rom_addr SHALL always equal PC.
REQ-016 SHALL fetch one byte per clock: the byte addressed in cycle N is sampled on the rising edge ending cycle N; PC increments on every sample.
REQ-017 In FETCH_OP, SHALL capture the opcode, record ins_pc, clear op1/op2, and decode the length; len 1 -> HOLD, else -> FETCH_B1.
REQ-018 In FETCH_B1, SHALL capture op1; len 2 -> HOLD, len 3 -> FETCH_B2. FETCH_B2 SHALL capture op2 -> HOLD.
REQ-019 SHALL decode length: 3 bytes for 0x75, 0x85; 2 bytes for 0x74, 0x76-0x7F, 0x86-0x8F, 0xA6-0xAF, 0xE5, 0xF5; 1 byte for 0x00, 0xE6-0xEF, 0xF6-0xFF; 1 byte for any other opcode.
REQ-020 SHALL assert ins_valid only in HOLD; all ins_* outputs SHALL be stable while ins_valid=1 and ins_ready=0.
REQ-021 A transfer SHALL occur on a rising edge with ins_valid=1 and ins_ready=1; the FSM then enters FETCH_OP. An n-byte instruction therefore occupies n+1 cycles at full throughput.
REQ-022 PC SHALL wrap from 2^ADDRWIDTH-1 to 0 with no flag, including mid-instruction.
REQ-023 jmp_en=1 on a rising edge in any state SHALL load PC=jmp_addr, enter FETCH_OP, drop ins_valid, and discard any partial instruction; it SHALL override a simultaneous transfer, and the held instruction counts as consumed.

Reset
REQ-024 rst=1 SHALL immediately set PC=0, state=FETCH_OP, ins_valid=0, and ins_opcode/op1/op2/pc/len/illegal=0; rom_cs SHALL therefore be 0 and rom_addr 0.
REQ-025 Reset asserted mid-instruction SHALL abandon it; after release, the first fetch SHALL be from address 0.

Configuration
REQ-026 With ILLEGAL_TRAP_EN defined, ins_illegal SHALL be 1 for opcodes outside REQ-019's listed set, and the instruction SHALL be treated as 1 byte.
REQ-027 Without ILLEGAL_TRAP_EN, ins_illegal SHALL be constant 0, with identical length behaviour.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the length constants (LEN1..LEN3), and the opcode constants used by the decoder.
REQ-029 The combinational sub-module ins_len_decode (opcode -> len, illegal) SHALL be instantiated once.

Verification
REQ-030 ROM bytes 74 07 F8 at 0x00, ready=1 -> instruction 1: opcode 0x74, op1 0x07, len 2, ins_pc 0x00, valid in cycle 3; instruction 2: opcode 0xF8, len 1, ins_pc 0x02.
REQ-031 Bytes 75 01 06 at 0x0C -> opcode 0x75, op1 0x01, op2 0x06, len 3, ins_pc 0x0C; next fetch from 0x0F.
REQ-032 ins_ready=0 for 5 cycles in HOLD -> outputs unchanged, rom_cs=1, PC unchanged; ready=1 -> one transfer, then fetch resumes.
REQ-033 jmp_en with jmp_addr=0x13 while in FETCH_B1 -> partial discarded, ins_valid stays 0, next opcode read from 0x13 (0x86), op1 0x20.
REQ-034 PC at 0xFE with bytes 75 AA BB at 0xFE/0xFF/0x00 -> op1 0xAA, op2 0xBB, next PC 0x01. With ILLEGAL_TRAP_EN, opcode 0xA5 -> ins_illegal=1, len 1.
REQ-035 rst pulse during FETCH_B2 -> outputs zero immediately; after release, the fetch restarts at address 0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit:
// FSM state encoding, instruction lengths and opcodes known to the decoder.
package inst_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_OP = 2'd0,
      FETCH_B1 = 2'd1,
      FETCH_B2 = 2'd2,
      HOLD     = 2'd3
   } state_t;

   localparam logic [1:0] LEN1 = 2'd1;
   localparam logic [1:0] LEN2 = 2'd2;
   localparam logic [1:0] LEN3 = 2'd3;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_L2_74 = 8'h74;
   localparam logic [7:0] OP_L3_75 = 8'h75;
   localparam logic [7:0] OP_L3_85 = 8'h85;
   localparam logic [7:0] OP_L2_E5 = 8'hE5;
   localparam logic [7:0] OP_L2_F5 = 8'hF5;

   // Row groups x6..xF share a length, keyed on the upper nibble
   localparam logic [3:0] ROW_7  = 4'h7;
   localparam logic [3:0] ROW_8  = 4'h8;
   localparam logic [3:0] ROW_A  = 4'hA;
   localparam logic [3:0] ROW_E  = 4'hE;
   localparam logic [3:0] ROW_F  = 4'hF;
   localparam logic [3:0] LO_MIN = 4'h6;

   function automatic logic in_row(
      input logic [7:0] op,
      input logic [3:0] row
   );
      return (op[7:4] == row) && (op[3:0] >= LO_MIN);
   endfunction

endpackage

// File: rtl/inst_fetch_ins_len_decode.sv
// Opcode -> instruction length and illegal flag.
// Define ILLEGAL_TRAP_EN to flag opcodes outside the supported set.
module ins_len_decode
   import inst_fetch_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] len,
   output logic       illegal
);

   logic is_l3;
   logic is_l2;

   assign is_l3 = (opcode == OP_L3_75) || (opcode == OP_L3_85);

   assign is_l2 = (opcode == OP_L2_74)
               || in_row(opcode, ROW_7)
               || in_row(opcode, ROW_8)
               || in_row(opcode, ROW_A)
               || (opcode == OP_L2_E5)
               || (opcode == OP_L2_F5);

   always_comb begin
      len = LEN1;
      if (is_l3) begin
         len = LEN3;
      end else if (is_l2) begin
         len = LEN2;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic is_l1;

   assign is_l1 = (opcode == OP_NOP)
               || in_row(opcode, ROW_E)
               || in_row(opcode, ROW_F);

   assign illegal = !(is_l1 || is_l2 || is_l3);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles 1..3 byte instructions from a
// program ROM and offers them on a valid/ready port. Option: ILLEGAL_TRAP_EN.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int ADDRWIDTH = 8
)
(
   input  logic                 clk,
   input  logic                 rst,
   output logic [ADDRWIDTH-1:0] rom_addr,
   output logic                 rom_cs,
   input  logic [7:0]           rom_data,
   output logic                 ins_valid,
   input  logic                 ins_ready,
   output logic [7:0]           ins_opcode,
   output logic [7:0]           ins_op1,
   output logic [7:0]           ins_op2,
   output logic [1:0]           ins_len,
   output logic [ADDRWIDTH-1:0] ins_pc,
   output logic                 ins_illegal,
   input  logic                 jmp_en,
   input  logic [ADDRWIDTH-1:0] jmp_addr
);

   localparam logic [ADDRWIDTH-1:0] PC_ONE =
      {{(ADDRWIDTH-1){1'b0}}, 1'b1};

   state_t               state;
   state_t               state_nxt;
   logic [ADDRWIDTH-1:0] pc;
   logic [1:0]           dec_len;
   logic                 dec_illegal;

   ins_len_decode u_dec (
      .opcode  (rom_data),
      .len     (dec_len),
      .illegal (dec_illegal)
   );

   assign rom_addr  = pc;
   assign rom_cs    = (state == HOLD);
   assign ins_valid = (state == HOLD);

   always_comb begin
      state_nxt = state;
      if (jmp_en) begin
         state_nxt = FETCH_OP;
      end else begin
         unique case (state)
            FETCH_OP: state_nxt = (dec_len == LEN1) ? HOLD : FETCH_B1;
            FETCH_B1: state_nxt = (ins_len == LEN3) ? FETCH_B2 : HOLD;
            FETCH_B2: state_nxt = HOLD;
            HOLD:     if (ins_ready) state_nxt = FETCH_OP;
            default:  state_nxt = FETCH_OP;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH_OP;
         pc          <= '0;
         ins_opcode  <= '0;
         ins_op1     <= '0;
         ins_op2     <= '0;
         ins_len     <= '0;
         ins_pc      <= '0;
         ins_illegal <= 1'b0;
      end else begin
         state <= state_nxt;

         // A redirect wins over both sampling and a pending transfer
         if (jmp_en) begin
            pc <= jmp_addr;
         end else if (state != HOLD) begin
            pc <= pc + PC_ONE;
         end

         if (!jmp_en) begin
            unique case (state)
               FETCH_OP: begin
                  ins_opcode  <= rom_data;
                  ins_op1     <= '0;
                  ins_op2     <= '0;
                  ins_pc      <= pc;
                  ins_len     <= dec_len;
                  ins_illegal <= dec_illegal;
               end
               FETCH_B1: ins_op1 <= rom_data;
               FETCH_B2: ins_op2 <= rom_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch with an instruction-level reference model
// and directed scenarios pinning the model to hand-computed values.
module tb_inst_fetch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rom_addr;
   logic       rom_cs;
   logic [7:0] rom_data = 8'h00;
   logic       ins_valid;
   logic       ins_ready = 1'b0;
   logic [7:0] ins_opcode;
   logic [7:0] ins_op1;
   logic [7:0] ins_op2;
   logic [1:0] ins_len;
   logic [7:0] ins_pc;
   logic       ins_illegal;
   logic       jmp_en = 1'b0;
   logic [7:0] jmp_addr = 8'h00;

   logic [7:0] rom [256];

   int n_assert = 0;
   int n_fail   = 0;

   inst_fetch #(.ADDRWIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_addr    (rom_addr),
      .rom_cs      (rom_cs),
      .rom_data    (rom_data),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .ins_opcode  (ins_opcode),
      .ins_op1     (ins_op1),
      .ins_op2     (ins_op2),
      .ins_len     (ins_len),
      .ins_pc      (ins_pc),
      .ins_illegal (ins_illegal),
      .jmp_en      (jmp_en),
      .jmp_addr    (jmp_addr)
   );

   always #5 clk = ~clk;

   // ROM registers its address on the falling edge
   always @(negedge clk) rom_data <= rom[rom_addr];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic int blen(input logic [7:0] o);
      if (o inside {8'h75, 8'h85}) return 3;
      if (o inside {8'h74, [8'h76:8'h7F], [8'h86:8'h8F],
                    [8'hA6:8'hAF], 8'hE5, 8'hF5}) return 2;
      return 1;
   endfunction

   function automatic bit listed(input logic [7:0] o);
      return (o inside {8'h75, 8'h85, 8'h74, [8'h76:8'h7F],
                        [8'h86:8'h8F], [8'hA6:8'hAF], 8'hE5,
                        8'hF5, 8'h00, [8'hE6:8'hEF],
                        [8'hF6:8'hFF]});
   endfunction

   function automatic bit exp_illegal(input logic [7:0] o);
`ifdef ILLEGAL_TRAP_EN
      return !listed(o);
`else
      return (o == 8'h00) && !listed(o);
`endif
   endfunction

   // Instruction-level model: where the current instruction starts,
   // how many bytes have been read, and whether it is on offer.
   logic [7:0] m_start = 8'h00;
   int         m_k     = 0;
   int         m_len   = 0;
   bit         m_valid = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_start = 8'h00;
         m_k     = 0;
         m_valid = 1'b0;
      end else if (jmp_en) begin
         m_start = jmp_addr;
         m_k     = 0;
         m_valid = 1'b0;
      end else if (m_valid) begin
         if (ins_ready) begin
            m_start = m_start + 8'(m_len);
            m_k     = 0;
            m_valid = 1'b0;
         end
      end else begin
         m_k++;
         if (m_k == blen(rom[m_start])) begin
            m_len   = m_k;
            m_valid = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] ea;
      logic [7:0] op;
      ea = m_valid ? m_start + 8'(m_len) : m_start + 8'(m_k);
      op = rom[m_start];
      chk("valid", 32'(ins_valid), 32'(m_valid));
      chk("rom_cs", 32'(rom_cs), 32'(m_valid));
      chk("rom_addr", 32'(rom_addr), 32'(ea));
      if (m_valid) begin
         chk("opcode", 32'(ins_opcode), 32'(op));
         chk("op1", 32'(ins_op1),
             32'(m_len >= 2 ? rom[8'(m_start + 8'd1)] : 8'h00));
         chk("op2", 32'(ins_op2),
             32'(m_len == 3 ? rom[8'(m_start + 8'd2)] : 8'h00));
         chk("len", 32'(ins_len), 32'(m_len));
         chk("pc", 32'(ins_pc), 32'(m_start));
         chk("illegal", 32'(ins_illegal), 32'(exp_illegal(op)));
      end
   end

   task automatic wait_valid();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = ins_valid;
      end
      chk("wait_valid", 32'(seen), 32'd1);
   endtask

   task automatic chk_ins(input string nm,
                          input logic [7:0] op,
                          input logic [7:0] o1,
                          input logic [7:0] o2,
                          input logic [1:0] ln,
                          input logic [7:0] pc);
      chk({nm, "_valid"}, 32'(ins_valid), 32'd1);
      chk({nm, "_opcode"}, 32'(ins_opcode), 32'(op));
      chk({nm, "_op1"}, 32'(ins_op1), 32'(o1));
      chk({nm, "_op2"}, 32'(ins_op2), 32'(o2));
      chk({nm, "_len"}, 32'(ins_len), 32'(ln));
      chk({nm, "_pc"}, 32'(ins_pc), 32'(pc));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, 32'(ins_valid), 32'd0);
      chk({nm, "_cs"}, 32'(rom_cs), 32'd0);
      chk({nm, "_addr"}, 32'(rom_addr), 32'd0);
      chk({nm, "_opcode"}, 32'(ins_opcode), 32'd0);
      chk({nm, "_op1"}, 32'(ins_op1), 32'd0);
      chk({nm, "_op2"}, 32'(ins_op2), 32'd0);
      chk({nm, "_len"}, 32'(ins_len), 32'd0);
      chk({nm, "_pc"}, 32'(ins_pc), 32'd0);
      chk({nm, "_illegal"}, 32'(ins_illegal), 32'd0);
   endtask

   task automatic jump(input logic [7:0] a);
      jmp_en   = 1'b1;
      jmp_addr = a;
      @(posedge clk);
      #1;
      jmp_en = 1'b0;
   endtask

   initial begin
      logic [7:0] s_op;
      logic [7:0] s_o1;
      logic [7:0] s_o2;

      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      rom[8'h00] = 8'h74; rom[8'h01] = 8'h07; rom[8'h02] = 8'hF8;
      rom[8'h0C] = 8'h75; rom[8'h0D] = 8'h01; rom[8'h0E] = 8'h06;
      rom[8'h10] = 8'h85; rom[8'h11] = 8'h11; rom[8'h12] = 8'h12;
      rom[8'h13] = 8'h86; rom[8'h14] = 8'h20;
      rom[8'h20] = 8'hA5;
      rom[8'hFE] = 8'h75; rom[8'hFF] = 8'hAA;

      repeat (2) @(posedge clk);
      #2;
      chk_zero("reset");

      // 74 07 F8 from address 0 at full throughput
      @(posedge clk);
      #1;
      rst       = 1'b0;
      ins_ready = 1'b1;
      @(negedge clk);
      chk("c1_valid", 32'(ins_valid), 32'd0);
      @(negedge clk);
      chk("c2_valid", 32'(ins_valid), 32'd0);
      @(negedge clk);
      chk_ins("i1", 8'h74, 8'h07, 8'h00, 2'd2, 8'h00);
      @(negedge clk);
      chk("c4_addr", 32'(rom_addr), 32'h02);
      @(negedge clk);
      chk_ins("i2", 8'hF8, 8'h00, 8'h00, 2'd1, 8'h02);
      @(posedge clk);
      #1;
      ins_ready = 1'b0;

      // three-byte instruction, then back-pressure for five cycles
      jump(8'h0C);
      wait_valid();
      chk_ins("i3", 8'h75, 8'h01, 8'h06, 2'd3, 8'h0C);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_ins("hold", 8'h75, 8'h01, 8'h06, 2'd3, 8'h0C);
         chk("hold_cs", 32'(rom_cs), 32'd1);
         chk("hold_addr", 32'(rom_addr), 32'h0F);
      end
      ins_ready = 1'b1;
      @(posedge clk);
      #1;
      ins_ready = 1'b0;
      @(negedge clk);
      chk("post_valid", 32'(ins_valid), 32'd0);
      chk("post_addr", 32'(rom_addr), 32'h0F);

      // redirect while collecting the first operand
      jump(8'h10);
      @(posedge clk);
      #1;
      jump(8'h13);
      @(negedge clk);
      chk("redir_valid", 32'(ins_valid), 32'd0);
      chk("redir_addr", 32'(rom_addr), 32'h13);
      wait_valid();
      chk_ins("i4", 8'h86, 8'h20, 8'h00, 2'd2, 8'h13);

      // wrap across the top of the address space
      rom[8'h00] = 8'hBB;
      jump(8'hFE);
      wait_valid();
      chk_ins("wrap", 8'h75, 8'hAA, 8'hBB, 2'd3, 8'hFE);
      ins_ready = 1'b1;
      @(posedge clk);
      #1;
      ins_ready = 1'b0;
      @(negedge clk);
      chk("wrap_next", 32'(rom_addr), 32'h01);

      // unsupported opcode
      jump(8'h20);
      wait_valid();
      chk("ill_op", 32'(ins_opcode), 32'hA5);
      chk("ill_len", 32'(ins_len), 32'd1);
`ifdef ILLEGAL_TRAP_EN
      chk("ill_flag", 32'(ins_illegal), 32'd1);
`else
      chk("ill_flag", 32'(ins_illegal), 32'd0);
`endif

      // reset in the middle of the last operand byte
      jump(8'h0C);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("b2_addr", 32'(rom_addr), 32'h0E);
      #1;
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      ins_ready = 1'b1;
      @(negedge clk);
      chk("restart_addr", 32'(rom_addr), 32'h00);
      chk("restart_valid", 32'(ins_valid), 32'd0);

      // random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         ins_ready = ($urandom_range(0, 3) != 0);
         jmp_en    = ($urandom_range(0, 24) == 0);
         jmp_addr  = 8'($urandom);
         rst       = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk);
      #1;
      rst    = 1'b0;
      jmp_en = 1'b0;
      repeat (4) @(negedge clk);

      s_op = ins_opcode;
      s_o1 = ins_op1;
      s_o2 = ins_op2;
      if (s_op === 8'hxx || s_o1 === 8'hxx || s_o2 === 8'hxx) begin
         chk("x_outputs", 32'd1, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
